// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// the table of legal byte-lane write-enable patterns and the wait-counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WAIT_CNT_W   = 4;
  localparam int LEGAL_WE_NUM = 8;

  // Byte, aligned halfword and full word lane patterns; slot 0 is the read pattern.
  localparam logic [4*LEGAL_WE_NUM-1:0] LEGAL_WE_LIST = {
    4'b1111, 4'b1100, 4'b0011, 4'b1000,
    4'b0100, 4'b0010, 4'b0001, 4'b0000
  };

  function automatic logic we_is_legal(input logic [3:0] we);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < LEGAL_WE_NUM; i++) begin
      if (LEGAL_WE_LIST[4*i +: 4] == we) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between an initiator and the data-memory responder.
interface dmem_responder_if;
  logic        stb;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (output stb, we, addr, wdata, input rdata, ack, err);
  modport slave  (input stb, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/dmem_bytelane_ram.sv
// Word-organised storage with one write enable per byte lane and an
// asynchronous read port; contents are never cleared.
module dmem_bytelane_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [3:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][k] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: samples a strobed request, optionally
// waits WAIT_CYCLES cycles, then answers with a one-cycle ack or err pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  dmem_responder_if.slave      bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
    WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t                state, state_nxt;
  logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;
  logic                  capture;
  logic                  enter_resp;

  logic [3:0]            we_q;
  logic [29:0]           word_q;
  logic [31:0]           wdata_q;

  logic [3:0]            we_sel;
  logic [29:0]           word_sel;
  logic [31:0]           wdata_sel;
  logic                  req_legal;
  logic                  ram_wr;
  logic [31:0]           ram_rdata;

  logic                  ack_nxt, err_nxt;
  logic [31:0]           rdata_nxt;

  // With no wait cycles the request is decided on the very edge that samples
  // it, so the live bus is used in IDLE and the captured copy afterwards.
  assign we_sel    = (state == IDLE) ? bus.we         : we_q;
  assign word_sel  = (state == IDLE) ? bus.addr[31:2] : word_q;
  assign wdata_sel = (state == IDLE) ? bus.wdata      : wdata_q;

  assign req_legal = we_is_legal(we_sel) && ({2'b00, word_sel} < 32'(DEPTH));
  assign ram_wr    = enter_resp && req_legal && rstn_i && (we_sel != 4'b0000);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (bus.stb) begin
          capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    ack_nxt   = enter_resp && req_legal;
    err_nxt   = enter_resp && !req_legal;
    rdata_nxt = (enter_resp && req_legal && (we_sel == 4'b0000)) ? ram_rdata : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      cnt       <= '0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bus.ack   <= ack_nxt;
      bus.err   <= err_nxt;
      bus.rdata <= rdata_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) begin
      we_q    <= bus.we;
      word_q  <= bus.addr[31:2];
      wdata_q <= bus.wdata;
    end
  end

  dmem_bytelane_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk_i),
    .wr_en (ram_wr),
    .be    (we_sel),
    .idx   (word_sel[IDX_W-1:0]),
    .wdata (wdata_sel),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: two instances (no wait states and three
// wait states) are driven and compared against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn    [2];
  logic        stb_d   [2];
  logic [3:0]  we_d    [2];
  logic [31:0] addr_d  [2];
  logic [31:0] wdata_d [2];
  logic        ack_o   [2];
  logic        err_o   [2];
  logic [31:0] rdata_o [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_mem [2][DEPTH];
  logic [3:0]  legal_tab [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  assign bus0.stb   = stb_d[0];
  assign bus0.we    = we_d[0];
  assign bus0.addr  = addr_d[0];
  assign bus0.wdata = wdata_d[0];
  assign ack_o[0]   = bus0.ack;
  assign err_o[0]   = bus0.err;
  assign rdata_o[0] = bus0.rdata;

  assign bus1.stb   = stb_d[1];
  assign bus1.we    = we_d[1];
  assign bus1.addr  = addr_d[1];
  assign bus1.wdata = wdata_d[1];
  assign ack_o[1]   = bus1.ack;
  assign err_o[1]   = bus1.err;
  assign rdata_o[1] = bus1.rdata;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk_i  (clk),
    .rstn_i (rstn[0]),
    .bus    (bus0)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut1 (
    .clk_i  (clk),
    .rstn_i (rstn[1]),
    .bus    (bus1)
  );

  function automatic int waitCycles(input int sel);
    return (sel == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] peek(input int sel, input logic [7:0] idx);
    if (sel == 0) return dut0.u_ram.mem[idx];
    return dut1.u_ram.mem[idx];
  endfunction

  function automatic logic [3:0] pickWe();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return legal_tab[r];
    return 4'($urandom);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  task automatic checkIdle(input int sel, input string tag);
    checkOutput({tag, "_flags"}, {30'b0, ack_o[sel], err_o[sel]}, 32'h0);
    checkOutput({tag, "_rdata"}, rdata_o[sel], 32'h0);
  endtask

  // Entered and left #1 after a rising edge with the responder idle.
  task automatic applyStimulus(input int sel, input logic [3:0] we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bit          we_ok, in_range, ok;
    logic [7:0]  idx;
    logic [31:0] exp_rdata;
    we_ok     = we inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                           4'b1000, 4'b0011, 4'b1100, 4'b1111};
    in_range  = (addr >> 2) < DEPTH;
    ok        = we_ok && in_range;
    idx       = addr[9:2];
    exp_rdata = (ok && we == 4'b0000) ? model_mem[sel][idx] : 32'h0;

    stb_d[sel]   = 1'b1;
    we_d[sel]    = we;
    addr_d[sel]  = addr;
    wdata_d[sel] = wdata;
    @(posedge clk); #1;
    for (int i = 0; i < waitCycles(sel); i++) begin
      checkOutput("wait_flags", {30'b0, ack_o[sel], err_o[sel]}, 32'h0);
      we_d[sel]    = 4'($urandom);
      addr_d[sel]  = $urandom;
      wdata_d[sel] = $urandom;
      if ($urandom_range(0, 3) == 0) stb_d[sel] = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("resp_ack", 32'(ack_o[sel]), 32'(ok));
    checkOutput("resp_err", 32'(err_o[sel]), 32'(!ok));
    checkOutput("resp_rdata", rdata_o[sel], exp_rdata);
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        if (we[k]) model_mem[sel][idx][8*k +: 8] = wdata[8*k +: 8];
      end
    end
    if (in_range) checkOutput("mem_word", peek(sel, idx), model_mem[sel][idx]);
    stb_d[sel] = 1'b0;
    @(posedge clk); #1;
    checkIdle(sel, "post_resp");
  endtask

  // Reset asserted `offset` edges after the sampling edge, while still waiting.
  task automatic abortWrite(input int sel, input int offset, input logic [7:0] idx);
    stb_d[sel]   = 1'b1;
    we_d[sel]    = 4'b1111;
    addr_d[sel]  = {22'b0, idx, 2'b00};
    wdata_d[sel] = 32'h12345678;
    @(posedge clk); #1;
    for (int i = 1; i < offset; i++) begin
      checkOutput("abort_wait_flags", {30'b0, ack_o[sel], err_o[sel]}, 32'h0);
      @(posedge clk); #1;
    end
    rstn[sel] = 1'b0;
    @(posedge clk); #1;
    checkIdle(sel, "abort_reset");
    rstn[sel]  = 1'b1;
    stb_d[sel] = 1'b0;
    for (int i = 0; i <= waitCycles(sel); i++) begin
      @(posedge clk); #1;
      checkIdle(sel, "abort_after");
    end
    checkOutput("abort_mem", peek(sel, idx), model_mem[sel][idx]);
  endtask

  // A request presented in the same edge as reset must leave no trace.
  task automatic resetWithStb(input int sel, input logic [7:0] idx);
    rstn[sel]    = 1'b0;
    stb_d[sel]   = 1'b1;
    we_d[sel]    = 4'b1111;
    addr_d[sel]  = {22'b0, idx, 2'b00};
    wdata_d[sel] = ~model_mem[sel][idx];
    @(posedge clk); #1;
    checkIdle(sel, "rststb_edge");
    rstn[sel]  = 1'b1;
    stb_d[sel] = 1'b0;
    for (int i = 0; i <= waitCycles(sel); i++) begin
      @(posedge clk); #1;
      checkIdle(sel, "rststb_after");
    end
    checkOutput("rststb_mem", peek(sel, idx), model_mem[sel][idx]);
  endtask

  // Strobe held high across two reads; acks must be W+2 cycles apart.
  task automatic backToBack(input int sel, input logic [7:0] idx);
    int first, second, cyc;
    first  = -1;
    second = -1;
    cyc    = 0;
    stb_d[sel]   = 1'b1;
    we_d[sel]    = 4'b0000;
    addr_d[sel]  = {22'b0, idx, 2'b00};
    wdata_d[sel] = $urandom;
    while (cyc < 40 && second < 0) begin
      @(posedge clk); #1;
      cyc++;
      if (ack_o[sel]) begin
        checkOutput("b2b_rdata", rdata_o[sel], model_mem[sel][idx]);
        if (first < 0) first = cyc;
        else           second = cyc;
      end
    end
    stb_d[sel] = 1'b0;
    checkOutput("b2b_second_ack_seen", 32'(second >= 0), 32'h1);
    checkOutput("b2b_first_latency", 32'(first), 32'(waitCycles(sel) + 1));
    if (second >= 0) checkOutput("b2b_gap", 32'(second - first), 32'(waitCycles(sel) + 2));
    @(posedge clk); #1;
    checkIdle(sel, "b2b_after");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rstn[s]    = 1'b0;
      stb_d[s]   = 1'b0;
      we_d[s]    = 4'b0000;
      addr_d[s]  = 32'h0;
      wdata_d[s] = 32'h0;
      for (int i = 0; i < DEPTH; i++) model_mem[s][i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkIdle(0, "reset0");
    checkIdle(1, "reset1");
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    @(posedge clk); #1;

    // Known contents everywhere: words 0..3 cleared, the rest random.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        applyStimulus(s, 4'b1111, 32'(i) << 2, (i < 4) ? 32'h0 : $urandom);
      end
    end

    applyStimulus(0, 4'b0011, 32'h0, 32'hDEADFFFF);
    checkOutput("word0_halfword", peek(0, 8'd0), 32'h0000FFFF);
    applyStimulus(0, 4'b1100, 32'h4, 32'hFFFF1234);
    checkOutput("word1_halfword", peek(0, 8'd1), 32'hFFFF0000);
    applyStimulus(0, 4'b0000, 32'h4, 32'h0);
    applyStimulus(0, 4'b0101, 32'h8, 32'hA5A5A5A5);
    checkOutput("word2_untouched", peek(0, 8'd2), 32'h0);
    applyStimulus(0, 4'b0000, 32'h400, 32'h0);
    applyStimulus(0, 4'b0000, 32'h3FC, 32'h0);
    applyStimulus(0, 4'b1111, 32'hFFFFFFFC, 32'h0BADBEEF);
    applyStimulus(1, 4'b1000, 32'h13, 32'h7700_0000);
    applyStimulus(1, 4'b0000, 32'h12, 32'h0);

    abortWrite(1, 2, 8'd5);
    resetWithStb(0, 8'd6);
    resetWithStb(1, 8'd7);
    backToBack(0, 8'd1);
    backToBack(1, 8'd4);

    for (int n = 0; n < 300; n++) begin
      int          s;
      logic [31:0] a;
      s = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else                           a = {22'b0, 8'($urandom), 2'($urandom)};
      applyStimulus(s, pickWe(), a, $urandom);
      if ($urandom_range(0, 29) == 0) backToBack(s, 8'($urandom));
      if ($urandom_range(0, 39) == 0) abortWrite(1, $urandom_range(1, 3), 8'($urandom));
    end

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        checkOutput("final_mem", peek(s, 8'(i)), model_mem[s][i]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning storage size in 32-bit words (power of two, 4..4096).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, meaning extra cycles inserted before ack/err (0..15).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port stb  input  1  request strobe, held high by initiator until ack or err.
REQ-006 SHALL have port we  input  4  byte-lane write enables; 4'b0000 = read.
REQ-007 SHALL have port addr  input  32  byte address; addr[1:0] ignored, word index = addr[31:2].
REQ-008 SHALL have port wdata  input  32  write data, lane k = wdata[8k+7:8k].
REQ-009 SHALL have port rdata  output  32  read data, valid only in the ack cycle.
REQ-010 SHALL have port ack  output  1  one-cycle pulse, transaction completed.
REQ-011 SHALL have port err  output  1  one-cycle pulse, transaction rejected.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP; all outputs registered.
REQ-013 IDLE: stb=1 at a rising edge SHALL capture we/addr/wdata and go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-014 WAIT: counter loaded with WAIT_CYCLES-1, decrements each cycle; at zero SHALL go to RESP.
REQ-015 Response latency SHALL be exactly WAIT_CYCLES+1 cycles from the stb-sampling edge to ack/err high.
REQ-016 RESP: exactly one of ack/err SHALL be high for one cycle; next state IDLE unconditionally.
REQ-017 stb high during RESP SHALL be ignored; a new request is sampled no earlier than the following IDLE cycle (one dead cycle between transactions).
REQ-018 Legal we set: 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111; any other pattern SHALL yield err.
REQ-019 Word index >= DEPTH SHALL yield err.
REQ-020 On err SHALL not modify storage; rdata SHALL be 0.
REQ-021 Legal write SHALL update only lanes with we[k]=1, committed at the edge entering RESP; other lanes unchanged.
REQ-022 Legal read SHALL drive rdata = stored word (all four lanes) during ack; no sign extension or lane shifting.
REQ-023 Outside the RESP cycle, rdata SHALL be 0.
REQ-024 stb changes during WAIT SHALL be ignored; captured request completes as sampled.
REQ-025 Read following write to same word SHALL return the written value (write visible at the next transaction).

Reset
REQ-026 rstn_i=0 at a rising edge SHALL force state IDLE, counter 0, ack=0, err=0, rdata=0.
REQ-027 Reset SHALL not clear storage contents.
REQ-028 Reset in WAIT SHALL abort the request: no write committed, no ack/err issued.
REQ-029 stb sampled in the same edge as rstn_i=0 SHALL be ignored.

Structure
REQ-030 Shared package dmem_pkg SHALL hold the FSM state enum, legal-we constant list, and WAIT counter width (4).
REQ-031 Storage SHALL be a sub-module dmem_bytelane_ram (DEPTH x 4 x 8 bits, per-lane write enable, combinational read).
REQ-032 Storage SHALL be accessible by hierarchical path for bench preload/inspection.

Verification
REQ-033 WAIT_CYCLES=0, write addr=0x0, we=0011, wdata=0xDEADFFFF onto word 0x00000000 -> ack one cycle after sampling; word 0 = 0x0000FFFF.
REQ-034 Then we=1100, addr=0x4, wdata=0xFFFF1234 onto word 1 = 0 -> word 1 = 0xFFFF0000; read addr=0x4 -> rdata=0xFFFF0000 with ack.
REQ-035 we=0101, addr=0x8 -> err pulse, ack=0, rdata=0, word 2 unchanged.
REQ-036 DEPTH=256, read addr=0x400 -> err pulse; addr=0x3FC -> ack.
REQ-037 WAIT_CYCLES=3, write we=1111 wdata=0x12345678; assert rstn_i=0 two cycles after sampling -> no ack/err, word unchanged; outputs 0.
REQ-038 Back-to-back: stb held high across two requests -> second ack exactly WAIT_CYCLES+2 cycles after first ack.
